// File: rtl/mf_impulse_sequencer.sv
// Matched-filter calibration sequencer: passes ADC samples through, or on start_i flushes the filter,
// injects one impulse per lane and records the output peak. MF_IMPULSE_BIPOLAR_EN adds a negative pass.
module mf_impulse_sequencer #(
    parameter int NSAMP        = 4,
    parameter int NBITS        = 12,
    parameter int IMPULSE_AMP  = 1024,
    parameter int FLUSH_CYCLES = 16,
    parameter int WINDOW       = 20,
    parameter int TOL          = 8
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [NSAMP*NBITS-1:0] adc_data_i,
    output logic [NSAMP*NBITS-1:0] mf_data_o,
    input  logic [NSAMP*NBITS-1:0] mf_result_i,
    output logic [NSAMP*NBITS-1:0] peak_val_o,
    output logic [NSAMP*8-1:0]     peak_idx_o,
    output logic [NSAMP*NBITS-1:0] neg_peak_val_o,
    output logic                   bipolar_err_o
);
    localparam int LW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam logic signed [NBITS-1:0] AMP_POS = NBITS'(IMPULSE_AMP);
    localparam logic signed [NBITS-1:0] VAL_MIN = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [15:0] FLUSH_LAST  = 16'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WINDOW_LAST = 16'(WINDOW - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(NSAMP - 1);

    typedef enum logic [2:0] {StIdle, StFlush, StInject, StCapture, StDone} state_t;

    // Peak index is 8 bits wide, so the whole capture window must fit in 256 positions.
    if (WINDOW * NSAMP > 256 || TOL < 0) begin : g_bad_cfg
        $error("mf_impulse_sequencer: WINDOW*NSAMP must not exceed 256 and TOL must be >= 0");
    end

    state_t                  r_state;
    logic [15:0]             r_cnt;
    logic [LW-1:0]           r_lane;
    logic                    r_busy;
    logic                    r_done;
    logic [NSAMP*NBITS-1:0]  r_mf_data;
    logic signed [NBITS-1:0] r_peak_val [NSAMP];
    logic [7:0]              r_peak_idx [NSAMP];

    logic [NSAMP*NBITS-1:0]  w_pattern;
    logic signed [NBITS-1:0] w_amp;
    logic signed [NBITS-1:0] w_best_val;
    logic signed [NBITS-1:0] w_sample;
    logic [7:0]              w_best_idx;
    logic                    w_neg;

`ifdef MF_IMPULSE_BIPOLAR_EN
    localparam int NB1 = NBITS + 1;
    localparam logic signed [NBITS-1:0] AMP_NEG = NBITS'(-IMPULSE_AMP);
    localparam logic signed [NBITS-1:0] VAL_MAX = {1'b0, {(NBITS-1){1'b1}}};

    logic                    r_neg;
    logic                    r_err;
    logic signed [NBITS-1:0] r_neg_val [NSAMP];
    logic signed [NBITS:0]   w_sum;
    logic [NBITS:0]          w_mag;
    logic                    w_err;

    assign w_neg = r_neg;
    assign w_amp = r_neg ? AMP_NEG : AMP_POS;

    // Symmetric response means positive and negative peaks cancel to within TOL.
    always_comb begin
        w_err = 1'b0;
        w_sum = '0;
        w_mag = '0;
        for (int k = 0; k < NSAMP; k++) begin
            w_sum = $signed({r_peak_val[k][NBITS-1], r_peak_val[k]})
                  + $signed({r_neg_val[k][NBITS-1], r_neg_val[k]});
            w_mag = w_sum[NBITS] ? -w_sum : w_sum;
            if (w_mag > NB1'(TOL)) begin
                w_err = 1'b1;
            end
        end
    end
`else
    assign w_neg = 1'b0;
    assign w_amp = AMP_POS;
`endif

    // Lanes scanned low to high with strict compare, so the earliest position wins ties.
    always_comb begin
        w_best_val = r_peak_val[r_lane];
        w_best_idx = r_peak_idx[r_lane];
        w_sample   = '0;
`ifdef MF_IMPULSE_BIPOLAR_EN
        if (r_neg) begin
            w_best_val = r_neg_val[r_lane];
        end
`endif
        for (int k = 0; k < NSAMP; k++) begin
            w_sample = mf_result_i[NBITS*k +: NBITS];
            if (w_neg ? (w_sample < w_best_val) : (w_sample > w_best_val)) begin
                w_best_val = w_sample;
                w_best_idx = 8'(r_cnt * 16'(NSAMP) + 16'(k));
            end
        end
    end

    always_comb begin
        w_pattern = '0;
        if (r_state == StInject) begin
            w_pattern[NBITS*r_lane +: NBITS] = w_amp;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_lane    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mf_data <= '0;
            for (int k = 0; k < NSAMP; k++) begin
                r_peak_val[k] <= '0;
                r_peak_idx[k] <= '0;
            end
`ifdef MF_IMPULSE_BIPOLAR_EN
            r_neg <= 1'b0;
            r_err <= 1'b0;
            for (int k = 0; k < NSAMP; k++) r_neg_val[k] <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_mf_data <= (r_state == StIdle || r_state == StDone) ? adc_data_i : w_pattern;
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_state <= StFlush;
                        r_cnt   <= '0;
                        r_lane  <= '0;
                        r_busy  <= 1'b1;
                        for (int k = 0; k < NSAMP; k++) begin
                            r_peak_val[k] <= '0;
                            r_peak_idx[k] <= '0;
                        end
`ifdef MF_IMPULSE_BIPOLAR_EN
                        r_neg <= 1'b0;
                        r_err <= 1'b0;
                        for (int k = 0; k < NSAMP; k++) r_neg_val[k] <= '0;
`endif
                    end
                end
                StFlush: begin
                    if (r_cnt == FLUSH_LAST) begin
                        r_cnt   <= '0;
                        r_state <= StInject;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StInject: begin
                    r_cnt   <= '0;
                    r_state <= StCapture;
`ifdef MF_IMPULSE_BIPOLAR_EN
                    if (r_neg) r_neg_val[r_lane] <= VAL_MAX;
                    else
`endif
                    begin
                        r_peak_val[r_lane] <= VAL_MIN;
                        r_peak_idx[r_lane] <= '0;
                    end
                end
                StCapture: begin
`ifdef MF_IMPULSE_BIPOLAR_EN
                    if (r_neg) r_neg_val[r_lane] <= w_best_val;
                    else
`endif
                    begin
                        r_peak_val[r_lane] <= w_best_val;
                        r_peak_idx[r_lane] <= w_best_idx;
                    end
                    if (r_cnt == WINDOW_LAST) begin
                        r_cnt <= '0;
                        if (r_lane != LANE_LAST) begin
                            r_lane  <= r_lane + 1'b1;
                            r_state <= StInject;
                        end
`ifdef MF_IMPULSE_BIPOLAR_EN
                        else if (!r_neg) begin
                            r_neg   <= 1'b1;
                            r_lane  <= '0;
                            r_state <= StInject;
                        end
`endif
                        else begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
`ifdef MF_IMPULSE_BIPOLAR_EN
                    r_err <= w_err;
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign mf_data_o = r_mf_data;

    for (genvar k = 0; k < NSAMP; k++) begin : g_out
        assign peak_val_o[NBITS*k +: NBITS] = r_peak_val[k];
        assign peak_idx_o[8*k +: 8]         = r_peak_idx[k];
`ifdef MF_IMPULSE_BIPOLAR_EN
        assign neg_peak_val_o[NBITS*k +: NBITS] = r_neg_val[k];
`else
        assign neg_peak_val_o[NBITS*k +: NBITS] = '0;
`endif
    end

`ifdef MF_IMPULSE_BIPOLAR_EN
    assign bipolar_err_o = r_err;
`else
    assign bipolar_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mf_impulse_sequencer.sv
// Scoreboard bench for mf_impulse_sequencer with a configurable mock matched filter.
module tb_mf_impulse_sequencer;
    localparam int NSAMP = 4;
    localparam int NBITS = 12;
    localparam int DW    = NSAMP * NBITS;
`ifdef MF_IMPULSE_BIPOLAR_EN
    localparam int BUSY_EXP = 184;
`else
    localparam int BUSY_EXP = 100;
`endif
    localparam logic [DW-1:0] ADC_RUN = 48'h5A5_3C3_0F0_123;

    typedef struct {
        int                  busy;
        logic [DW-1:0]       pv;
        logic [NSAMP*8-1:0]  pi;
        logic [DW-1:0]       nv;
        logic                err;
        logic [DW-1:0]       adc;
        int                  tag;
    } exp_t;

    logic              aclk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              busy_o, done_o, bipolar_err_o;
    logic [DW-1:0]     adc_data_i = '0;
    logic [DW-1:0]     mf_data_o, mf_result_i, peak_val_o, neg_peak_val_o;
    logic [NSAMP*8-1:0] peak_idx_o;

    logic [DW-1:0] h1 = '0, h2 = '0, h3 = '0, h4 = '0, h5 = '0;
    int mode = 0;

    exp_t          sb_q[$];
    logic [DW-1:0] pt_q[$];
    exp_t          cur;
    bit            pend = 0;
    int            busy_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    mf_impulse_sequencer #(
        .NSAMP(NSAMP), .NBITS(NBITS), .IMPULSE_AMP(1024), .FLUSH_CYCLES(16), .WINDOW(20), .TOL(8)
    ) dut (
        .aclk(aclk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .adc_data_i(adc_data_i), .mf_data_o(mf_data_o), .mf_result_i(mf_result_i),
        .peak_val_o(peak_val_o), .peak_idx_o(peak_idx_o), .neg_peak_val_o(neg_peak_val_o),
        .bipolar_err_o(bipolar_err_o)
    );

    always #5 aclk = ~aclk;

    // Mock filter: 0 identity 3-cycle delay, 1 zeros, 2 echoes of 500 at +2/+5, 3 half gain on negatives
    always @(posedge aclk) begin
        h1 <= mf_data_o;
        h2 <= h1;
        h3 <= h2;
        h4 <= h3;
        h5 <= h4;
    end

    always_comb begin
        mf_result_i = '0;
        for (int k = 0; k < NSAMP; k++) begin
            case (mode)
                0: mf_result_i[NBITS*k +: NBITS] = h3[NBITS*k +: NBITS];
                2: mf_result_i[NBITS*k +: NBITS] = ((h2[NBITS*k +: NBITS] != 0) ? 12'd500 : 12'd0)
                                                + ((h5[NBITS*k +: NBITS] != 0) ? 12'd500 : 12'd0);
                3: mf_result_i[NBITS*k +: NBITS] = h3[NBITS*k+NBITS-1]
                        ? {1'b1, h3[NBITS*k+1 +: NBITS-1]} : h3[NBITS*k +: NBITS];
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int pv, input int ib, input int step, input int nv,
                                input bit err, input int tag);
        exp_t e;
`ifndef MF_IMPULSE_BIPOLAR_EN
        nv  = 0;
        err = 1'b0;
`endif
        e.busy = BUSY_EXP;
        e.adc  = ADC_RUN;
        e.err  = err;
        e.tag  = tag;
        e.pv   = '0;
        e.pi   = '0;
        e.nv   = '0;
        for (int p = 0; p < NSAMP; p++) begin
            e.pv[NBITS*p +: NBITS] = NBITS'(pv);
            e.pi[8*p +: 8]         = 8'(ib + step * p);
            e.nv[NBITS*p +: NBITS] = NBITS'(nv);
        end
        return e;
    endfunction

    // Monitor: samples 2 time units after each active edge
    always @(posedge aclk) begin
        #2;
        if (rst) begin
            busy_cnt = 0;
            pend     = 0;
        end else begin
            if (pend) begin
                chk($sformatf("run%0d_bipolar_err", cur.tag), 64'(bipolar_err_o), 64'(cur.err));
                chk($sformatf("run%0d_done_width", cur.tag), 64'(done_o), 64'd0);
                chk($sformatf("run%0d_passthru_after_done", cur.tag), 64'(mf_data_o), 64'(cur.adc));
                pend = 0;
            end
            if (busy_o) busy_cnt++;
            if (pt_q.size() > 0) begin
                logic [DW-1:0] v;
                v = pt_q.pop_front();
                chk("passthru", 64'(mf_data_o), 64'(v));
            end
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1, expected 0");
                end else begin
                    cur = sb_q.pop_front();
                    chk($sformatf("run%0d_busy_cycles", cur.tag), 64'(busy_cnt), 64'(cur.busy));
                    chk($sformatf("run%0d_busy_low_at_done", cur.tag), 64'(busy_o), 64'd0);
                    chk($sformatf("run%0d_mf_zero_at_done", cur.tag), 64'(mf_data_o), 64'd0);
                    chk($sformatf("run%0d_peak_val", cur.tag), 64'(peak_val_o), 64'(cur.pv));
                    chk($sformatf("run%0d_peak_idx", cur.tag), 64'(peak_idx_o), 64'(cur.pi));
                    chk($sformatf("run%0d_neg_peak_val", cur.tag), 64'(neg_peak_val_o),
                        64'(cur.nv));
                    pend = 1;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run(input exp_t e, input int hold);
        int t;
        sb_q.push_back(e);
        @(negedge aclk) start_i = 1'b1;
        @(negedge aclk);
        repeat (hold) @(negedge aclk);
        start_i = 1'b0;
        t = 0;
        while ((sb_q.size() != 0 || pend) && t < 400) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL run%0d_timeout: got no done_o within 400 cycles, expected one", e.tag);
            sb_q.delete();
        end
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_mf_data", 64'(mf_data_o), 64'd0);
        chk("reset_peak_val", 64'(peak_val_o), 64'd0);
        chk("reset_peak_idx", 64'(peak_idx_o), 64'd0);
        chk("reset_neg_peak", 64'(neg_peak_val_o), 64'd0);
        chk("reset_bipolar_err", 64'(bipolar_err_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] v;
            for (int k = 0; k < NSAMP; k++) v[NBITS*k +: NBITS] = NBITS'(i * 291 - k * 700 + 5);
            adc_data_i = v;
            pt_q.push_back(v);
            @(negedge aclk);
        end
        adc_data_i = ADC_RUN;
        @(negedge aclk);

        mode = 0;
        run(mk(1024, 12, 1, -1024, 1'b0, 1), 0);
        run(mk(1024, 12, 1, -1024, 1'b0, 2), 60);   // start_i held well into the run
        mode = 1;
        run(mk(0, 0, 0, 0, 1'b0, 3), 0);
        mode = 2;
        run(mk(500, 8, 1, 0, 1'b1, 4), 0);

        // Abort at busy cycle 40: lane 0 already holds a result by then
        begin
            int nb;
            int t;
            bit seen;
            mode = 0;
            @(negedge aclk) start_i = 1'b1;
            @(negedge aclk) start_i = 1'b0;
            nb = busy_o ? 1 : 0;
            t  = 0;
            while (nb < 40 && t < 200) begin
                @(negedge aclk);
                if (busy_o) nb++;
                t++;
            end
            chk("abort_reached_cycle40", 64'(nb), 64'd40);
            rst = 1'b1;
            @(posedge aclk);
            #2;
            chk("abort_busy", 64'(busy_o), 64'd0);
            chk("abort_done", 64'(done_o), 64'd0);
            chk("abort_mf_data", 64'(mf_data_o), 64'd0);
            chk("abort_peak_val", 64'(peak_val_o), 64'd0);
            chk("abort_peak_idx", 64'(peak_idx_o), 64'd0);
            @(negedge aclk) rst = 1'b0;
            seen = 0;
            repeat (120) begin
                @(negedge aclk);
                if (done_o) seen = 1;
            end
            chk("abort_no_done", 64'(seen), 64'd0);
        end

        run(mk(1024, 12, 1, -1024, 1'b0, 5), 0);
`ifdef MF_IMPULSE_BIPOLAR_EN
        mode = 3;
        run(mk(1024, 12, 1, -512, 1'b1, 6), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
